// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: runs one req/ack data-memory transaction per load/store.
// Optional wait timeout with sticky err is enabled by defining MEM_WB_TIMEOUT_EN.
module mem_wb_stage #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter logic [7:0]  MAX_WAIT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  input  logic [3:0]  WB_Dest_in,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        freeze,
  output logic        err,
  output logic        WB_EN,
  output logic [3:0]  WB_Dest,
  output logic [31:0] WB_Value,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_next;
  logic        mem_op;
  logic        timeout;
  logic        load_q;
  logic        wb_en_q;
  logic [3:0]  dest_q;

  // Handshake: mem_req is high for exactly the WAIT cycles; the transaction completes in
  // the cycle mem_ack is seen high while mem_req is high. An ack outside WAIT is ignored.
  assign mem_op    = valid_in & (MEM_R_EN_in | MEM_W_EN_in);
  assign mem_req   = (state == WAIT);
  assign state_dbg = state;

`ifdef MEM_WB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // An ack arriving in the limit cycle takes priority over the timeout.
  assign timeout = (state == WAIT) & ~mem_ack & (wait_cnt == MAX_WAIT - 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE) wait_cnt <= 8'd0;
      else if (!mem_ack) wait_cnt <= wait_cnt + 8'd1;
      if (timeout) err <= 1'b1;
    end
  end
`else
  logic unused_max_wait;

  assign unused_max_wait = ^MAX_WAIT;
  assign timeout         = 1'b0;
  assign err             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // A timed-out instruction is retired (freeze released) so upstream moves past it.
  always_comb begin
    state_next = state;
    freeze     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          freeze     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack || timeout) state_next = IDLE;
        else                    freeze     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      load_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      dest_q    <= 4'd0;
      WB_EN     <= 1'b0;
      WB_Dest   <= 4'd0;
      WB_Value  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Both enables set counts as a store.
            mem_we    <= MEM_W_EN_in;
            mem_addr  <= (ALU_Res - ADDR_BASE) & 32'hFFFF_FFFC;
            mem_wdata <= Val_Rm;
            load_q    <= ~MEM_W_EN_in;
            wb_en_q   <= WB_EN_in;
            dest_q    <= WB_Dest_in;
            WB_EN     <= 1'b0;
          end else begin
            WB_EN    <= valid_in & WB_EN_in;
            WB_Dest  <= WB_Dest_in;
            WB_Value <= ALU_Res;
          end
        end
        WAIT: begin
          WB_EN <= 1'b0;
          if (mem_ack && load_q) begin
            WB_EN    <= wb_en_q;
            WB_Dest  <= dest_q;
            WB_Value <= mem_rdata;
          end
        end
        default: WB_EN <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus randomized instruction stream against a
// transaction-level model with a writeback scoreboard.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [3:0]  WB_Dest_in;
  logic [31:0] ALU_Res, Val_Rm;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, freeze, err, WB_EN;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic        state_dbg;

  localparam logic [31:0] BASE = 32'd1024;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_BASE(BASE), .MAX_WAIT(8'd4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MEM_R_EN_in(MEM_R_EN_in),
    .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in), .WB_Dest_in(WB_Dest_in),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .freeze(freeze), .err(err), .WB_EN(WB_EN),
    .WB_Dest(WB_Dest), .WB_Value(WB_Value), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every observed writeback must match the oldest expected one.
  task automatic wb_check(input logic exp_en);
    logic [35:0] e;
    check("wb_en", WB_EN, exp_en);
    if (WB_EN === 1'b1) begin
      if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wb_dest_value", {WB_Dest, WB_Value}, e);
      end
    end
  endtask

  task automatic idle_inputs();
    valid_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; WB_EN_in = 0;
    WB_Dest_in = 0; ALU_Res = 0; Val_Rm = 0; mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic do_alu(input logic v, input logic r, input logic w, input logic wbe,
                        input logic [3:0] dest, input logic [31:0] alu, input logic stray);
    valid_in = v; MEM_R_EN_in = v ? 1'b0 : r; MEM_W_EN_in = v ? 1'b0 : w;
    WB_EN_in = wbe; WB_Dest_in = dest; ALU_Res = alu; Val_Rm = $urandom;
    mem_ack = stray; mem_rdata = $urandom;
    #1 check("alu_freeze", freeze, 0);
    next_cycle();
    mem_ack = 0;
    if (v && wbe) exp_q.push_back({dest, alu});
    wb_check(v & wbe);
    check("alu_wb_fields", {WB_Dest, WB_Value}, {dest, alu});
    check("alu_req", mem_req, 0);
  endtask

  task automatic do_mem(input logic r, input logic w, input logic wbe, input logic [3:0] dest,
                        input logic [31:0] alu, input logic [31:0] val, input int j,
                        input logic [31:0] rdata);
    logic [31:0] addr;
    addr = ((alu - BASE) >> 2) << 2;
    valid_in = 1; MEM_R_EN_in = r; MEM_W_EN_in = w; WB_EN_in = wbe;
    WB_Dest_in = dest; ALU_Res = alu; Val_Rm = val; mem_ack = 0;
    #1 check("mem_freeze_issue", freeze, 1);
    next_cycle();
    check("mem_req_on", mem_req, 1);
    check("mem_we", mem_we, w);
    check("mem_addr", mem_addr, addr);
    check("mem_wdata", mem_wdata, val);
    wb_check(0);
    for (int i = 1; i < j; i++) begin
      check("mem_freeze_wait", freeze, 1);
      next_cycle();
      check("mem_req_hold", mem_req, 1);
      check("mem_addr_hold", mem_addr, addr);
      wb_check(0);
    end
    mem_ack = 1; mem_rdata = rdata;
    #1 check("mem_freeze_ack", freeze, 0);
    next_cycle();
    mem_ack = 0; valid_in = 0;
    if (!w && wbe) exp_q.push_back({dest, rdata});
    wb_check(!w && wbe);
    check("mem_req_off", mem_req, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we_addr_wdata", {mem_we, mem_addr, mem_wdata}, 0);
    check("rst_wb", {WB_EN, WB_Dest, WB_Value}, 0);
    check("rst_err", err, 0);
    rst = 1;

    // Directed cases
    do_alu(1, 0, 0, 1, 4'd3, 32'h42, 0);
    do_mem(1, 0, 1, 4'd5, 32'd1028, 32'h0, 3, 32'hDEAD_BEEF);
    do_mem(0, 1, 1, 4'd9, 32'd1032, 32'h1234, 1, 32'hFFFF_0000);
    do_mem(1, 0, 1, 4'd2, 32'd1103, 32'h0, 1, 32'hCAFE_0001);
    do_mem(1, 1, 1, 4'd6, 32'd5, 32'h55, 2, 32'h1111_2222);
    do_alu(1, 0, 0, 0, 4'd1, 32'h77, 1);
    do_alu(0, 1, 1, 1, 4'd4, 32'h99, 1);

`ifdef MEM_WB_TIMEOUT_EN
    valid_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0; WB_EN_in = 1;
    WB_Dest_in = 4'd8; ALU_Res = 32'd2048; mem_ack = 0;
    #1 check("to_freeze_issue", freeze, 1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      check("to_req", mem_req, 1);
      check("to_freeze", freeze, 1);
      check("to_err_early", err, 0);
      next_cycle();
    end
    check("to_req_last", mem_req, 1);
    check("to_freeze_release", freeze, 0);
    next_cycle();
    valid_in = 0;
    check("to_req_drop", mem_req, 0);
    check("to_err_set", err, 1);
    wb_check(0);
    exp_err = 1'b1;
    do_alu(1, 0, 0, 1, 4'd10, 32'hABCD, 0);
    check("to_err_sticky", err, 1);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind < 2)
        do_alu($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), 4'($urandom), $urandom, $urandom_range(0, 1));
      else if (kind == 2)
        do_mem(1, 0, $urandom_range(0, 1), 4'($urandom), $urandom, $urandom,
               $urandom_range(1, 4), $urandom);
      else
        do_mem($urandom_range(0, 1), 1, $urandom_range(0, 1), 4'($urandom), $urandom,
               $urandom, $urandom_range(1, 4), $urandom);
    end
    check("err_after_random", err, exp_err);

    // Asynchronous reset in the middle of a load
    valid_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0; WB_EN_in = 1;
    WB_Dest_in = 4'd7; ALU_Res = 32'd2000; Val_Rm = 32'h5; mem_ack = 0;
    next_cycle();
    check("arst_req_before", mem_req, 1);
    #1 rst = 0;
    #1;
    check("arst_req_async", mem_req, 0);
    check("arst_mem_regs", {mem_we, mem_addr, mem_wdata}, 0);
    check("arst_wb", {WB_EN, WB_Dest, WB_Value}, 0);
    check("arst_err", err, 0);
    idle_inputs();
    next_cycle();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      wb_check(0);
      check("arst_req_after", mem_req, 0);
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
